qdma_flr_responder: RTL and testbench

//  User-side responder for the DMA Function Level Reset (FLR) handshake.
//  - Accepts flr_set/flr_clr/flr_fnc pulses driven by the QDMA fabric output interface.
//  - Queues pending functions and asks user logic to quiesce each one.
//  - Signals completion back to the DMA as a flr_done pulse, with timeout protection.
//  - Sits between the fabric output interface and the user C2H/H2C engines.

---
 rtl/qdma_flr_responder.sv | 167 ++++++++++++++++
 tb/tb_qdma_flr_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/qdma_flr_responder.sv
// qdma_flr_responder
//   User-side responder for the QDMA Function Level Reset handshake.
//   FLR start/cancel pulses from the fabric are queued. Each pending
//   function is then handed to user logic as a quiesce request. Completion
//   goes back to the DMA as a one-cycle flr_done pulse, and a timeout forces
//   completion if user logic never acknowledges.
//
// Ports
//   axi_aclk, axi_reset_n       clock, synchronous active-low reset
//   flr_set, flr_clr, flr_fnc   FLR start / cancel pulses and their function
//   quiesce_req, quiesce_fnc    level request to user logic, function to quiesce
//   quiesce_ack                 user logic finished quiescing quiesce_fnc
//   flr_done_vld, flr_done_fnc  one-cycle completion pulse and its function
//   flr_timeout                 completion was forced by the quiesce timer
//   pend_ovf                    sticky: an flr_set was dropped on a full queue
//   busy                        queue non-empty or a request in flight
module qdma_flr_responder #(
    parameter int FNC_W      = 8,
    parameter int DEPTH      = 4,
    parameter int QUIESCE_TO = 1024
) (
    input  logic             axi_aclk,
    input  logic             axi_reset_n,
    input  logic             flr_set,
    input  logic             flr_clr,
    input  logic [FNC_W-1:0] flr_fnc,
    output logic             quiesce_req,
    output logic [FNC_W-1:0] quiesce_fnc,
    input  logic             quiesce_ack,
    output logic             flr_done_vld,
    output logic [FNC_W-1:0] flr_done_fnc,
    output logic             flr_timeout,
    output logic             pend_ovf,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(QUIESCE_TO);

    typedef struct packed {
        logic [FNC_W-1:0] fnc;
        logic             cancel;
    } ent_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    ent_t   [DEPTH-1:0] fifo_q, fifo_d;
    logic   [AW:0]      wr_q, wr_d, rd_q, rd_d, cnt;
    state_t             state_q, state_d;
    logic   [FNC_W-1:0] fnc_q, fnc_d;
    logic   [TW-1:0]    tmr_q, tmr_d;
    logic               to_q, to_d, ovf_q, ovf_d;

    logic [DEPTH-1:0] hit, live_hit;
    logic             empty, full, pop, dup, push_req, head_kill, clr_act, tmr_max;
    ent_t             head;

    assign cnt   = wr_q - rd_q;
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign head  = fifo_q[rd_q[AW-1:0]];

    // A slot is occupied when its distance from the read pointer is below
    // the fill count. Only occupied slots take part in dedupe and cancel.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [AW-1:0] off;
        assign off         = AW'(g) - rd_q[AW-1:0];
        assign hit[g]      = ({1'b0, off} < cnt) && (fifo_q[g].fnc == flr_fnc);
        assign live_hit[g] = hit[g] && !fifo_q[g].cancel;
    end

    // An uncancelled pending entry or the in-flight function swallows a
    // repeat set. A cancelled match does not, so a re-issued FLR is queued.
    assign dup      = (|live_hit) || ((state_q != S_IDLE) && (fnc_q == flr_fnc));
    assign push_req = flr_set && !flr_clr && !dup;
    // A cancel that arrives while the head is being popped still kills it.
    assign head_kill = head.cancel || (flr_clr && (head.fnc == flr_fnc));
    assign clr_act   = flr_clr && (flr_fnc == fnc_q);
    assign tmr_max   = (tmr_q == TW'(QUIESCE_TO - 1));

    always_comb begin
        state_d = state_q;
        fnc_d   = fnc_q;
        tmr_d   = tmr_q;
        to_d    = to_q;
        ovf_d   = ovf_q;
        fifo_d  = fifo_q;
        wr_d    = wr_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!head_kill) begin
                        state_d = S_REQ;
                        fnc_d   = head.fnc;
                        tmr_d   = '0;
                        to_d    = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (!tmr_max) tmr_d = tmr_q + TW'(1);
                // A cancel for the active function beats both ack and timeout.
                if (clr_act) begin
                    state_d = S_IDLE;
                end else if (quiesce_ack) begin
                    state_d = S_DONE;
                end else if (tmr_max) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                to_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            if (flr_clr && hit[i]) fifo_d[i].cancel = 1'b1;
        end

        // When the queue is full, a pop in the same cycle frees the write slot.
        if (push_req) begin
            if (full && !pop) begin
                ovf_d = 1'b1;
            end else begin
                fifo_d[wr_q[AW-1:0]] = '{fnc: flr_fnc, cancel: 1'b0};
                wr_d = wr_q + (AW+1)'(1);
            end
        end
    end

    assign rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;

    always_ff @(posedge axi_aclk) begin
        if (!axi_reset_n) begin
            state_q <= S_IDLE;
            fifo_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fnc_q   <= '0;
            tmr_q   <= '0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fifo_q  <= fifo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fnc_q   <= fnc_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quiesce_req  = (state_q == S_REQ);
    assign quiesce_fnc  = fnc_q;
    assign flr_done_vld = (state_q == S_DONE);
    assign flr_done_fnc = (state_q == S_DONE) ? fnc_q : '0;
    assign flr_timeout  = (state_q == S_DONE) && to_q;
    assign pend_ovf     = ovf_q;
    assign busy         = !empty || (state_q != S_IDLE);
endmodule

// File: tb/tb_qdma_flr_responder.sv
module tb_qdma_flr_responder;
    logic       clk = 1'b0;
    logic       rst_n, set, clr, ack;
    logic [7:0] fnc;
    logic       req, dv, to, ovf, bsy;
    logic [7:0] qfnc, dfnc;

    always #5 clk = ~clk;

    qdma_flr_responder #(.FNC_W(8), .DEPTH(4), .QUIESCE_TO(16)) dut (
        .axi_aclk    (clk),
        .axi_reset_n (rst_n),
        .flr_set     (set),
        .flr_clr     (clr),
        .flr_fnc     (fnc),
        .quiesce_req (req),
        .quiesce_fnc (qfnc),
        .quiesce_ack (ack),
        .flr_done_vld(dv),
        .flr_done_fnc(dfnc),
        .flr_timeout (to),
        .pend_ovf    (ovf),
        .busy        (bsy)
    );

    typedef struct {
        logic       rst_n, set, clr;
        logic [7:0] fnc;
        logic       ack;
        logic       req;
        logic [7:0] qfnc;
        logic       dv;
        logic [7:0] dfnc;
        logic       to, ovf, busy;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t v(logic r, logic s, logic c, logic [7:0] f, logic a,
                               logic eq, logic [7:0] eqf, logic edv, logic [7:0] edf,
                               logic eto, logic eovf, logic eb);
        vec_t x;
        x.rst_n = r; x.set = s; x.clr = c; x.fnc = f; x.ack = a;
        x.req = eq; x.qfnc = eqf; x.dv = edv; x.dfnc = edf;
        x.to = eto; x.ovf = eovf; x.busy = eb;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive for one cycle, then sample 1 time unit after the edge.
    task automatic cyc(logic r, logic s, logic c, logic [7:0] f, logic a);
        rst_n = r; set = s; clr = c; fnc = f; ack = a;
        @(posedge clk);
        #1;
        set = 1'b0; clr = 1'b0; ack = 1'b0;
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; set = 1'b0; clr = 1'b0; fnc = '0; ack = 1'b0;

        // Sequence A: single FLR with ack 3 cycles after req.
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,5,0, 0,0,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 1,5,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 1,5,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 1,5,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,1, 0,0,1,5,0,0,1));
        tbl.push_back(v(1,0,0,0,0, 0,0,0,0,0,0,0));
        // Sequence B: 1..5 back-to-back fill the queue, 6 overflows.
        tbl.push_back(v(1,1,0,1,0, 0,0,0,0,0,0,1));
        tbl.push_back(v(1,1,0,2,0, 1,1,0,0,0,0,1));
        tbl.push_back(v(1,1,0,3,0, 1,1,0,0,0,0,1));
        tbl.push_back(v(1,1,0,4,0, 1,1,0,0,0,0,1));
        tbl.push_back(v(1,1,0,5,0, 1,1,0,0,0,0,1));
        tbl.push_back(v(1,1,0,6,0, 1,1,0,0,0,1,1));
        tbl.push_back(v(1,0,0,0,1, 0,0,1,1,0,1,1));
        for (int k = 2; k <= 5; k++) begin
            tbl.push_back(v(1,0,0,0,0, 0,0,0,0,0,1,1));
            tbl.push_back(v(1,0,0,0,0, 1,8'(k),0,0,0,1,1));
            tbl.push_back(v(1,0,0,0,1, 0,0,1,8'(k),0,1,1));
        end
        tbl.push_back(v(1,0,0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,0,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst_n, tbl[i].set, tbl[i].clr, tbl[i].fnc, tbl[i].ack);
            chk($sformatf("v%0d.req", i), 32'(req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("v%0d.qfnc", i), 32'(qfnc), 32'(tbl[i].qfnc));
            chk($sformatf("v%0d.done", i), 32'(dv), 32'(tbl[i].dv));
            if (tbl[i].dv) chk($sformatf("v%0d.dfnc", i), 32'(dfnc), 32'(tbl[i].dfnc));
            chk($sformatf("v%0d.timeout", i), 32'(to), 32'(tbl[i].to));
            chk($sformatf("v%0d.ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("v%0d.busy", i), 32'(bsy), 32'(tbl[i].busy));
        end

        // Clear of the active function in the same cycle as ack: no done.
        cyc(0,0,0,0,0);
        cyc(1,1,0,7,0);
        cyc(1,0,0,0,0);
        chk("clr_ack.req", 32'(req), 1);
        chk("clr_ack.qfnc", 32'(qfnc), 7);
        cyc(1,0,1,7,1);
        chk("clr_ack.req_drop", 32'(req), 0);
        chk("clr_ack.no_done", 32'(dv), 0);
        chk("clr_ack.busy", 32'(bsy), 0);
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1,0,0,0,0);
            dcount += int'(dv);
        end
        chk("clr_ack.no_late_done", dcount, 0);

        // Cancel of a queued entry behind the active one.
        cyc(0,0,0,0,0);
        cyc(1,1,0,3,0);
        cyc(1,1,0,9,0);
        chk("cancel.req3", 32'(qfnc), 3);
        cyc(1,0,1,9,0);
        chk("cancel.still_req", 32'(req), 1);
        cyc(1,0,0,0,1);
        chk("cancel.done", 32'(dv), 1);
        chk("cancel.dfnc", 32'(dfnc), 3);
        dcount = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1,0,0,0,1);
            dcount += int'(dv) + int'(req);
        end
        chk("cancel.nothing_more", dcount, 0);
        chk("cancel.idle", 32'(bsy), 0);

        // Timeout at req+16 with QUIESCE_TO=16.
        cyc(0,0,0,0,0);
        cyc(1,1,0,11,0);
        cyc(1,0,0,0,0);
        chk("to.req", 32'(req), 1);
        dcount = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc(1,0,0,0,0);
            dcount += int'(dv) + int'(to) + int'(!req);
        end
        chk("to.held_15", dcount, 0);
        cyc(1,0,0,0,0);
        chk("to.done", 32'(dv), 1);
        chk("to.timeout", 32'(to), 1);
        chk("to.dfnc", 32'(dfnc), 11);
        cyc(1,0,0,0,0);
        chk("to.pulse_1cyc", 32'(to), 0);

        // Dedupe against pending and active entries.
        cyc(0,0,0,0,0);
        cyc(1,1,0,4,0);
        cyc(1,1,0,4,0);
        cyc(1,1,0,4,0);
        chk("dedupe.req", 32'(qfnc), 4);
        cyc(1,0,0,0,1);
        chk("dedupe.done", 32'(dv), 1);
        cyc(1,0,0,0,0);
        chk("dedupe.empty", 32'(bsy), 0);

        // Reset while in REQ with two pending entries.
        cyc(0,0,0,0,0);
        cyc(1,1,0,1,0);
        cyc(1,1,0,2,0);
        cyc(1,1,0,3,0);
        chk("rst.busy_before", 32'(bsy), 1);
        cyc(0,0,0,0,0);
        chk("rst.outs", {req, dv, to, ovf, bsy}, 0);
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1,0,0,0,0);
            dcount += int'(dv) + int'(req) + int'(bsy);
        end
        chk("rst.quiet_after", dcount, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
